// File: rtl/priority_decoder_if.sv
// Handshake and output bundle for priority_decoder: code in over valid/ready,
// one-hot strobes plus status out.
interface priority_decoder_if;
    logic       in_valid;
    logic       s1;
    logic       s0;
    logic       in_ready;
    logic       a3;
    logic       a2;
    logic       a1;
    logic       a0;
    logic       busy;
    logic       done;
    logic [7:0] event_cnt;

    modport master (
        output in_valid, s1, s0,
        input  in_ready, a3, a2, a1, a0, busy, done, event_cnt
    );

    modport slave (
        input  in_valid, s1, s0,
        output in_ready, a3, a2, a1, a0, busy, done, event_cnt
    );
endinterface

// File: rtl/priority_decoder.sv
// Registered 2-to-4 decoder: holds the one-hot line for HOLD cycles, then
// forces GAP idle cycles, and counts accepted codes modulo 256.
module priority_decoder #(
    parameter int HOLD  = 4,
    parameter int GAP   = 1,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    priority_decoder_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       a_q, a_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       event_cnt_q, event_cnt_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        event_cnt_d = event_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    state_d     = ST_DRIVE;
                    a_d         = 4'b0001 << {bus.s1, bus.s0};
                    cnt_d       = HOLD_LD;
                    event_cnt_d = event_cnt_q + 8'd1;
                end
            end
            ST_DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (GAP > 0) begin
                    state_d = ST_GAP;
                    a_d     = '0;
                    cnt_d   = GAP_LD;
                end else begin
                    state_d = ST_IDLE;
                    a_d     = '0;
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
                else             state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                a_d     = '0;
            end
        endcase
        // Status flags are registered copies of what the next state will be.
        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DRIVE) && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            event_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            event_cnt_q <= event_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.a3        = a_q[3];
    assign bus.a2        = a_q[2];
    assign bus.a1        = a_q[1];
    assign bus.a0        = a_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.event_cnt = event_cnt_q;
endmodule

// File: tb/tb_priority_decoder.sv
// Bench for priority_decoder: two instances (HOLD=4/GAP=1 and HOLD=1/GAP=0)
// compared every cycle against an age-since-accept reference model.
module tb_priority_decoder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    priority_decoder_if ifa ();
    priority_decoder_if ifb ();

    priority_decoder #(.HOLD(4), .GAP(1), .CNT_W(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    priority_decoder #(.HOLD(1), .GAP(0), .CNT_W(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: each instance is either idle or 'age' edges past its
    // last accept; outputs follow from age versus HOLD and GAP.
    int hold_p [2] = '{4, 1};
    int gap_p  [2] = '{1, 0};
    bit active [2];
    bit rdy    [2];
    bit acc    [2];
    int age    [2];
    int code   [2];
    int ev     [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic set_in(input int d, input bit v, input int c);
        logic [1:0] cc;
        cc = 2'(c);
        if (d == 0) begin
            ifa.in_valid = v; ifa.s1 = cc[1]; ifa.s0 = cc[0];
        end else begin
            ifb.in_valid = v; ifb.s1 = cc[1]; ifb.s0 = cc[0];
        end
    endtask

    function automatic bit in_valid_of(input int d);
        return (d == 0) ? ifa.in_valid : ifb.in_valid;
    endfunction

    function automatic int code_of(input int d);
        return (d == 0) ? int'({ifa.s1, ifa.s0}) : int'({ifb.s1, ifb.s0});
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            active[d] = 0; rdy[d] = 0; acc[d] = 0; age[d] = 0; ev[d] = 0;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            acc[d] = 0;
            if (rst_n) begin
                if (in_valid_of(d) && rdy[d]) begin
                    acc[d]    = 1;
                    active[d] = 1;
                    age[d]    = 0;
                    code[d]   = code_of(d);
                    ev[d]     = (ev[d] + 1) % 256;
                end else if (active[d]) begin
                    age[d]++;
                    if (age[d] >= hold_p[d] + gap_p[d]) active[d] = 0;
                end
                rdy[d] = !active[d];
            end
        end
    endtask

    task automatic cmp_one(input int d, input logic [3:0] a, input logic r,
                           input logic b, input logic dn, input logic [7:0] e);
        logic [3:0] ea;
        ea = (active[d] && age[d] < hold_p[d]) ? 4'(1 << code[d]) : 4'b0000;
        check($sformatf("a[%0d]", d), 32'(a), 32'(ea));
        check($sformatf("onehot0[%0d]", d), 32'($onehot0(a)), 32'd1);
        check($sformatf("in_ready[%0d]", d), 32'(r), 32'(rdy[d]));
        check($sformatf("busy[%0d]", d), 32'(b), 32'(active[d]));
        check($sformatf("done[%0d]", d), 32'(dn), 32'(active[d] && age[d] == hold_p[d] - 1));
        check($sformatf("event_cnt[%0d]", d), 32'(e), 32'(ev[d]));
    endtask

    task automatic cmp_all();
        cmp_one(0, {ifa.a3, ifa.a2, ifa.a1, ifa.a0}, ifa.in_ready, ifa.busy, ifa.done, ifa.event_cnt);
        cmp_one(1, {ifb.a3, ifb.a2, ifb.a1, ifb.a0}, ifb.in_ready, ifb.busy, ifb.done, ifb.event_cnt);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cmp_all();
    endtask

    // Asynchronous reset taken between edges; outputs must clear with no clock.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        cmp_all();
        repeat (2) begin
            @(negedge clk);
            cmp_all();
        end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic wait_accept(input int d, input int max_cyc);
        bit got;
        got = 0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            cycle();
            got = acc[d];
        end
        check($sformatf("accept_timeout[%0d]", d), 32'(got), 32'd1);
    endtask

    initial begin
        int idx;
        int n_acc;
        int seq [4] = '{0, 1, 2, 3};

        rst_n = 1'b0;
        set_in(0, 0, 0);
        set_in(1, 0, 0);
        model_reset();

        // Reset held three cycles, then release and wait one edge for in_ready.
        repeat (3) begin
            @(negedge clk);
            cmp_all();
        end
        rst_n = 1'b1;
        cycle();
        check("ready_after_release", 32'(ifa.in_ready), 32'd1);
        check("evcnt_after_release", 32'(ifa.event_cnt), 32'd0);

        // Single decode of code 10.
        set_in(0, 1, 2);
        wait_accept(0, 10);
        set_in(0, 0, 0);
        check("single_a2", 32'({ifa.a3, ifa.a2, ifa.a1, ifa.a0}), 32'h4);
        repeat (8) cycle();
        check("single_evcnt", 32'(ifa.event_cnt), 32'd1);

        // All four codes back-to-back with in_valid held high.
        do_reset();
        idx = 0;
        set_in(0, 1, seq[0]);
        for (int i = 0; i < 100 && idx < 4; i++) begin
            cycle();
            if (acc[0]) begin
                idx++;
                if (idx < 4) set_in(0, 1, seq[idx]);
            end
        end
        set_in(0, 0, 0);
        check("b2b_accepts", 32'(idx), 32'd4);
        repeat (6) cycle();
        check("b2b_evcnt", 32'(ifa.event_cnt), 32'd4);

        // HOLD=1/GAP=0 instance: 11 then 00 with an all-zero cycle between.
        set_in(1, 1, 3);
        wait_accept(1, 10);
        check("b_a3", 32'({ifb.a3, ifb.a2, ifb.a1, ifb.a0}), 32'h8);
        set_in(1, 1, 0);
        cycle();
        check("b_idle_zero", 32'({ifb.a3, ifb.a2, ifb.a1, ifb.a0}), 32'h0);
        cycle();
        check("b_a0", 32'({ifb.a3, ifb.a2, ifb.a1, ifb.a0}), 32'h1);
        set_in(1, 0, 0);
        repeat (3) cycle();

        // Random traffic on both instances.
        for (int i = 0; i < 300; i++) begin
            set_in(0, ($urandom % 4) != 0, int'($urandom % 4));
            set_in(1, ($urandom % 3) != 0, int'($urandom % 4));
            cycle();
        end
        set_in(0, 0, 0);
        set_in(1, 0, 0);
        repeat (6) cycle();

        // Reset during hold cycle 2 of code 01.
        do_reset();
        set_in(0, 1, 1);
        wait_accept(0, 10);
        set_in(0, 0, 0);
        cycle();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_a1", 32'(ifa.a1), 32'd0);
        check("midrst_busy", 32'(ifa.busy), 32'd0);
        check("midrst_evcnt", 32'(ifa.event_cnt), 32'd0);
        model_reset();
        cmp_all();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        set_in(0, 1, int'($urandom % 4));
        wait_accept(0, 10);
        set_in(0, 0, 0);
        repeat (6) cycle();

        // Wrap of event_cnt across 257 accepts.
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 4000 && n_acc < 257; i++) begin
            set_in(0, 1, int'($urandom % 4));
            cycle();
            if (acc[0]) begin
                n_acc++;
                if (n_acc == 255) check("wrap_255", 32'(ifa.event_cnt), 32'd255);
                if (n_acc == 256) check("wrap_256", 32'(ifa.event_cnt), 32'd0);
                if (n_acc == 257) check("wrap_257", 32'(ifa.event_cnt), 32'd1);
            end
        end
        set_in(0, 0, 0);
        check("wrap_accepts", 32'(n_acc), 32'd257);
        repeat (6) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/priority_decoder.md
# priority_decoder

Registered 2-to-4 decoder, the inverse of the team's 4-to-2 priority encoder (a3..a0 -> s1,s0). It accepts an encoded index {s1,s0} over a valid/ready handshake. It drives the matching one-hot line on a3..a0 for a programmable number of cycles, then forces a programmable idle gap. It sits downstream of the encoder to regenerate request strobes and keeps a wrap-around count of decoded events.

## Interface
Parameters:
- HOLD, default 4: cycles the one-hot output is held. Legal range 1..2^CNT_W-1.
- GAP, default 1: idle cycles with all outputs zero after each hold. Legal range 0..2^CNT_W-1.
- CNT_W, default 4: width of the internal hold/gap down-counter.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: reset. Asynchronous, active-low.
- in_valid, input, 1: code {s1,s0} is presented.
- s1, input, 1: index MSB.
- s0, input, 1: index LSB.
- in_ready, output, 1: block can accept a code. Registered.
- a3, output, 1: one-hot line 3, high for code 11. Registered.
- a2, output, 1: one-hot line 2, high for code 10. Registered.
- a1, output, 1: one-hot line 1, high for code 01. Registered.
- a0, output, 1: one-hot line 0, high for code 00. Registered.
- busy, output, 1: state is DRIVE or GAP. Registered.
- done, output, 1: one-cycle pulse on the last hold cycle. Registered.
- event_cnt, output, 8: number of accepted codes, modulo 256.

## Operation
- FSM states: IDLE, DRIVE, GAP. A single down-counter cnt[CNT_W-1:0] serves both DRIVE and GAP.
- Accept condition: in_valid && in_ready at a rising edge.
- IDLE -> DRIVE on accept:
  - latch {s1,s0};
  - set exactly one of a3..a0;
  - load cnt = HOLD-1;
  - event_cnt += 1.
- DRIVE:
  - a3..a0 hold their value;
  - if cnt != 0, decrement cnt;
  - if cnt == 0 and GAP > 0, go to GAP with a3..a0 cleared and cnt = GAP-1;
  - if cnt == 0 and GAP == 0, go to IDLE with a3..a0 cleared.
- GAP: a3..a0 are 0. If cnt != 0, decrement; if cnt == 0, go to IDLE.
- in_ready = 1 exactly when the registered state is IDLE. It is computed as a register from next-state.
- busy = 1 in DRIVE and GAP.
- done = 1 during the final DRIVE cycle, i.e. while state is DRIVE and cnt == 0.
- a3..a0 are one-hot or all-zero at all times. Two or more lines high simultaneously is an error.
- s1/s0 are ignored when not accepted. Changes to s1/s0 during DRIVE do not affect the outputs.
- event_cnt wraps from 255 to 0 with no flag.

## Timing
- Reset (rst_n low, asynchronous):
  - state = IDLE, cnt = 0;
  - a3..a0 = 0, busy = 0, done = 0, event_cnt = 0;
  - in_ready = 0.
- After rst_n rises: the first rising edge sets in_ready = 1. No code is accepted on that edge.
- Latency: a code accepted at edge N appears on a3..a0 after edge N. The line stays high for exactly HOLD cycles.
- in_ready falls on the accepting edge and rises again HOLD+GAP cycles later.
- Minimum accept-to-accept spacing is HOLD+GAP+1 cycles. Even with GAP = 0, there is at least one all-zero output cycle between strobes, spent in IDLE.
- in_valid held high continuously: a new code is accepted at every first IDLE edge.
- Reset asserted mid-DRIVE or mid-GAP: outputs clear immediately without waiting for a clock. The pending hold is discarded and event_cnt returns to 0.
- HOLD = 1: done and the single active output cycle coincide.

## Test plan
- Reset then idle: rst_n = 0 for 3 cycles, then 1 -> all outputs 0 during reset; in_ready = 1 after the first edge post-release; event_cnt = 0.
- Single decode, HOLD = 4, GAP = 1: send {s1,s0} = 10 -> a2 = 1 for exactly 4 cycles, others 0; done on the 4th; 1 zero cycle in GAP; in_ready back after 5 cycles; event_cnt = 1.
- All codes back-to-back with in_valid held high, sending 00, 01, 10, 11 -> a0, a1, a2, a3 strobe in order, each 4 cycles, never overlapping; event_cnt = 4.
- GAP = 0, HOLD = 1: two consecutive codes 11 then 00 -> a3 high for 1 cycle, then 1 all-zero IDLE cycle, then a0 high for 1 cycle.
- Reset mid-operation: pull rst_n low at hold cycle 2 of code 01 -> a1, busy and event_cnt drop to 0 without a clock edge; normal operation resumes after release.
- Counter wrap: accept 257 codes -> event_cnt reads 255 after 255 accepts, 0 after 256, and 1 after 257.
